// File: rtl/des_block_sequencer_if.sv
// Stream-side and DES-core-side handshake bundle for des_block_sequencer.
// slave: the sequencer's view; master: the environment (DMA side plus core).
interface des_block_sequencer_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] eng_message;
  logic [63:0] eng_key;
  logic        eng_enable;
  logic        eng_ack;
  logic [63:0] eng_result;
  logic        eng_done;

  modport slave (
    input  in_data, in_valid, out_ready, eng_result, eng_done,
    output in_ready, out_data, out_valid, eng_message, eng_key, eng_enable, eng_ack
  );

  modport master (
    output in_data, in_valid, out_ready, eng_result, eng_done,
    input  in_ready, out_data, out_valid, eng_message, eng_key, eng_enable, eng_ack
  );
endinterface

// File: rtl/des_block_sequencer.sv
// Feeds 64-bit blocks one at a time through a multi-cycle DES decrypt core, with a latency
// watchdog and delivered-block counter. Define DES_SEQ_CBC_EN for CBC chaining (ECB otherwise).
module des_block_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [63:0]        key_in,
  input  logic               key_load,
`ifdef DES_SEQ_CBC_EN
  input  logic [63:0]        iv_in,
  input  logic               iv_load,
`endif
  des_block_sequencer_if.slave bus,
  output logic               busy,
  output logic               err,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   blk_count
);

  localparam int              WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    ACK       = 3'd3,
    OUT       = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [63:0]       key_r, msg_r, out_r;
  logic [WD_W-1:0]   wd_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              in_ready_r, busy_r, enable_r, ack_r, out_valid_r, err_r;
  logic              accept_s, capture_s, timeout_s, deliver_s;

`ifdef DES_SEQ_CBC_EN
  logic [63:0]       chain_r;

  function automatic logic [63:0] unchain(input logic [63:0] result, input logic [63:0] chain);
    return result ^ chain;
  endfunction
`endif

  // Next-state decode; done beats a coincident watchdog expiry.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    deliver_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          accept_s = 1'b1;
          state_s  = ISSUE;
        end else begin
          state_s  = IDLE;
        end
      end
      ISSUE: state_s = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.eng_done) begin
          capture_s = 1'b1;
          state_s   = ACK;
        end else if (wd_r == WD_LAST) begin
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = WAIT_DONE;
        end
      end
      ACK: state_s = OUT;
      OUT: begin
        if (bus.out_ready) begin
          deliver_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = OUT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus registered Moore outputs, error flag and block counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      enable_r    <= 1'b0;
      ack_r       <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      enable_r    <= (state_s == ISSUE);
      ack_r       <= (state_s == ACK);
      out_valid_r <= (state_s == OUT);
      if (timeout_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end
      if (deliver_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Key, message, result, chain and watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_r   <= 64'd0;
      msg_r   <= 64'd0;
      out_r   <= 64'd0;
      wd_r    <= {WD_W{1'b0}};
`ifdef DES_SEQ_CBC_EN
      chain_r <= 64'd0;
`endif
    end else begin
      if (state_r == IDLE && key_load) begin
        key_r <= key_in;
      end
      if (accept_s) begin
        msg_r <= bus.in_data;
      end
      if (state_r == ISSUE) begin
        wd_r <= {WD_W{1'b0}};
      end else if (state_r == WAIT_DONE && !capture_s && !timeout_s) begin
        wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
      end
`ifdef DES_SEQ_CBC_EN
      // Chain only moves in IDLE (IV) or at delivery, so it is stable from capture to handshake.
      if (capture_s) begin
        out_r <= unchain(bus.eng_result, chain_r);
      end
      if (state_r == IDLE && iv_load) begin
        chain_r <= iv_in;
      end else if (deliver_s) begin
        chain_r <= msg_r;
      end
`else
      if (capture_s) begin
        out_r <= bus.eng_result;
      end
`endif
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_r;
  assign bus.eng_message = msg_r;
  assign bus.eng_key     = key_r;
  assign bus.eng_enable  = enable_r;
  assign bus.eng_ack     = ack_r;
  assign busy            = busy_r;
  assign err             = err_r;
  assign blk_count       = cnt_r;

endmodule

// File: tb/tb_des_block_sequencer.sv
// Scoreboard bench for des_block_sequencer: behavioural core model, randomized blocks,
// latencies and back-pressure; a negedge monitor pops expected results on each out handshake.
module tb_des_block_sequencer;
  localparam int TIMEOUT = 24;
  localparam int CNT_W   = 16;
  localparam int HANG    = -1;

  logic              clk = 1'b0;
  logic              reset;
  logic [63:0]       key_in;
  logic              key_load;
  logic              err_clr;
  logic              busy;
  logic              err;
  logic [CNT_W-1:0]  blk_count;
`ifdef DES_SEQ_CBC_EN
  logic [63:0]       iv_in;
  logic              iv_load;
`endif

  des_block_sequencer_if bus ();

  des_block_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_load  (key_load),
`ifdef DES_SEQ_CBC_EN
    .iv_in     (iv_in),
    .iv_load   (iv_load),
`endif
    .bus       (bus),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference model state
  logic [63:0]      key_m   = 64'd0;
  logic [63:0]      chain_m = 64'd0;
  logic             err_m   = 1'b0;
  logic [CNT_W-1:0] cnt_m   = '0;
  logic [63:0]      out_q[$];
  logic [127:0]     iss_q[$];
  int               n_issued = 0;
  int               n_done   = 0;

  // core model controls / monitor observations
  int               core_lat = 0;
  logic [63:0]      core_res = 64'd0;
  int               bp_mode  = 0;
  int               n_en     = 0;
  int               n_ack    = 0;
  int               t_acc    = 0;
  int               last_lat = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core model: done asserted in the lat-th WAIT_DONE cycle (0-based), held until ack.
  initial begin : core_model
    int          ccnt;
    bit          pend;
    logic [63:0] cres;
    pend = 1'b0;
    ccnt = 0;
    cres = 64'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.eng_done = 1'b0;
        pend = 1'b0;
      end else if (bus.eng_enable) begin
        pend = (core_lat >= 0);
        ccnt = core_lat;
        cres = core_res;
      end else if (bus.eng_ack) begin
        bus.eng_done = 1'b0;
      end else if (pend) begin
        if (ccnt == 0) begin
          bus.eng_done = 1'b1;
          pend = 1'b0;
        end else begin
          ccnt--;
        end
      end
      bus.eng_result = bus.eng_done ? cres : 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // Downstream back-pressure: 0 always ready, 1 random, 2 stalled.
  initial forever begin
    @(posedge clk);
    #2;
    bus.out_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard.
  initial begin : monitor
    logic             prev_ov, prev_hs, prev_en;
    logic [63:0]      prev_data;
    logic [CNT_W-1:0] exp_cnt;
    logic [127:0]     e;
    prev_ov = 1'b0; prev_hs = 1'b0; prev_en = 1'b0; prev_data = 64'd0; exp_cnt = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ov = 1'b0; prev_hs = 1'b0; prev_en = 1'b0; exp_cnt = '0;
      end else begin
        if (bus.in_valid && bus.in_ready) t_acc = cyc;
        if (bus.eng_enable) begin
          n_en++;
          check("enable_single_pulse", 64'(prev_en), 64'd0);
          if (iss_q.size() == 0) begin
            fail_now("unexpected_enable");
          end else begin
            e = iss_q.pop_front();
            check("eng_key_at_issue", bus.eng_key, e[127:64]);
            check("eng_message_at_issue", bus.eng_message, e[63:0]);
          end
        end
        if (bus.eng_ack) n_ack++;
        if (prev_ov && !prev_hs) begin
          check("out_valid_hold", 64'(bus.out_valid), 64'd1);
          check("out_data_hold", bus.out_data, prev_data);
        end
        if (bus.out_valid) begin
          check("in_ready_low_while_out", 64'(bus.in_ready), 64'd0);
          if (!prev_ov) last_lat = cyc - t_acc;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (out_q.size() == 0) fail_now("unexpected_output");
          else check("out_data", bus.out_data, out_q.pop_front());
          check("blk_count_before_hs", 64'(blk_count), 64'(exp_cnt));
          exp_cnt = exp_cnt + 1'b1;
        end
        prev_ov   = bus.out_valid;
        prev_hs   = bus.out_valid && bus.out_ready;
        prev_data = bus.out_data;
        prev_en   = bus.eng_enable;
      end
    end
  end

  task automatic send_block(input logic [63:0] msg, input int lat, input logic [63:0] res,
                            input bit kl, input logic [63:0] kv);
    int g = 0;
    core_lat = lat;
    core_res = res;
    bus.in_data  = msg;
    bus.in_valid = 1'b1;
    key_in   = kv;
    key_load = kl;
    if (kl) key_m = kv;
    while (!bus.in_ready && g < 50) begin
      tick();
      key_load = 1'b0;
      g++;
    end
    if (g == 50) begin
      fail_now("in_ready_wait");
    end else begin
      iss_q.push_back({key_m, msg});
      n_issued++;
      if (lat >= 0 && lat <= TIMEOUT - 1) begin
`ifdef DES_SEQ_CBC_EN
        out_q.push_back(res ^ chain_m);
        chain_m = msg;
`else
        out_q.push_back(res);
`endif
        n_done++;
        cnt_m = cnt_m + 1'b1;
      end else begin
        err_m = 1'b1;
      end
    end
    tick();
    bus.in_valid = 1'b0;
    key_load     = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 300) begin
      tick();
      g++;
    end
    if (g == 300) fail_now("wait_idle");
    check("err_flag", 64'(err), 64'(err_m));
    check("blk_count", 64'(blk_count), 64'(cnt_m));
  endtask

  task automatic idle_ops();
    if ($urandom_range(0, 3) == 0) begin
      key_in = {$urandom, $urandom};
      key_load = 1'b1;
      key_m = key_in;
      tick();
      key_load = 1'b0;
      check("eng_key_after_load", bus.eng_key, key_m);
    end
    if (err_m && $urandom_range(0, 2) == 0) begin
      err_clr = 1'b1;
      err_m = 1'b0;
      tick();
      err_clr = 1'b0;
      check("err_after_clr", 64'(err), 64'(err_m));
    end
`ifdef DES_SEQ_CBC_EN
    if ($urandom_range(0, 4) == 0) begin
      iv_in = {$urandom, $urandom};
      iv_load = 1'b1;
      chain_m = iv_in;
      tick();
      iv_load = 1'b0;
    end
`endif
  endtask

  initial begin : stimulus
    logic [63:0] exp_bp;
    int          g;
    int          lat;
    reset = 1'b1; key_in = 64'd0; key_load = 1'b0; err_clr = 1'b0;
    bus.in_data = 64'd0; bus.in_valid = 1'b0;
`ifdef DES_SEQ_CBC_EN
    iv_in = 64'd0; iv_load = 1'b0;
`endif
    repeat (2) tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_blk_count", 64'(blk_count), 64'd0);
    check("rst_eng_key", bus.eng_key, 64'd0);
    check("rst_eng_enable", 64'(bus.eng_enable), 64'd0);
    reset = 1'b0;
    tick();

    // key load + single block, 20-cycle core
    key_in = 64'h1334_5779_9BBC_DFF1; key_load = 1'b1; key_m = key_in;
    tick();
    key_load = 1'b0;
    check("key_load_idle", bus.eng_key, 64'h1334_5779_9BBC_DFF1);
    send_block(64'h85E8_1354_0F0A_B405, 20, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0);
    wait_idle();
    check("latency_in_to_out", 64'(last_lat), 64'd24);
    check("single_enable_count", 64'(n_en), 64'd1);
    check("single_ack_count", 64'(n_ack), 64'd1);

    // back-pressure for 10 cycles
    bp_mode = 2;
    send_block(64'hA5A5_0000_FFFF_1234, 5, 64'h0BAD_CAFE_1234_5678, 1'b0, 64'd0);
    exp_bp = out_q[$];
    g = 0;
    while (!bus.out_valid && g < 100) begin tick(); g++; end
    if (g == 100) fail_now("bp_out_valid_wait");
    repeat (10) begin
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_data", bus.out_data, exp_bp);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bp_mode = 0;
    tick();
    check("bp_release_idle", 64'(busy), 64'd0);
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_queue_drained", 64'(out_q.size()), 64'd0);
    wait_idle();

    // key write ignored while busy
    send_block(64'h1111_2222_3333_4444, 15, 64'h5555_6666_7777_8888, 1'b0, 64'd0);
    repeat (4) tick();
    key_in = 64'hFFFF_FFFF_FFFF_FFFF; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check("key_ignored_busy", bus.eng_key, key_m);
    wait_idle();
    key_load = 1'b1; key_m = key_in;
    tick();
    key_load = 1'b0;
    check("key_load_after_busy", bus.eng_key, 64'hFFFF_FFFF_FFFF_FFFF);

    // key write and block accept in the same cycle
    send_block(64'h0F0F_0F0F_0F0F_0F0F, 3, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 64'h0A0B_0C0D_0E0F_1011);
    wait_idle();

    // timeout, then recovery, then set-beats-clear
    send_block(64'hDEAD_BEEF_0000_0001, HANG, 64'd0, 1'b0, 64'd0);
    repeat (TIMEOUT) tick();
    check("to_err_before", 64'(err), 64'd0);
    check("to_busy_last_wait", 64'(busy), 64'd1);
    tick();
    check("to_err_set", 64'(err), 64'd1);
    check("to_idle", 64'(busy), 64'd0);
    check("to_no_out_valid", 64'(bus.out_valid), 64'd0);
    wait_idle();
    send_block(64'h2222_3333_4444_5555, 7, 64'h9999_8888_7777_6666, 1'b0, 64'd0);
    wait_idle();
    send_block(64'hDEAD_BEEF_0000_0002, HANG, 64'd0, 1'b0, 64'd0);
    repeat (TIMEOUT) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_set_beats_clear", 64'(err), 64'd1);
    err_clr = 1'b1; err_m = 1'b0;
    tick();
    err_clr = 1'b0;
    check("err_clr_alone", 64'(err), 64'd0);

    // done coincides with watchdog expiry; zero-latency core
    send_block(64'h7777_0000_7777_0000, TIMEOUT - 1, 64'h1234_0000_5678_0000, 1'b0, 64'd0);
    wait_idle();
    send_block(64'h0000_0000_0000_0001, 0, 64'h8000_0000_0000_0000, 1'b0, 64'd0);
    wait_idle();

    // reset mid WAIT_DONE
    send_block(64'hCCCC_CCCC_CCCC_CCCC, HANG, 64'd0, 1'b0, 64'd0);
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("mid_rst_eng_message", bus.eng_message, 64'd0);
    check("mid_rst_eng_key", bus.eng_key, 64'd0);
    check("mid_rst_out_data", bus.out_data, 64'd0);
    check("mid_rst_blk_count", 64'(blk_count), 64'd0);
    out_q.delete(); iss_q.delete();
    key_m = 64'd0; chain_m = 64'd0; err_m = 1'b0; cnt_m = '0;
    tick();
    reset = 1'b0;
    send_block(64'h3141_5926_5358_9793, 9, 64'h2718_2818_2845_9045, 1'b0, 64'd0);
    wait_idle();

`ifdef DES_SEQ_CBC_EN
    iv_in = 64'h1111_1111_1111_1111; iv_load = 1'b1; chain_m = iv_in;
    tick();
    iv_load = 1'b0;
    send_block(64'hC1C1_C1C1_0000_1111, 6, 64'hA1A1_0000_B2B2_0000, 1'b0, 64'd0);
    wait_idle();
    send_block(64'hC2C2_C2C2_2222_3333, 11, 64'h0000_D3D3_0000_E4E4, 1'b0, 64'd0);
    wait_idle();
`endif

    // randomized blocks with random back-pressure
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      idle_ops();
      case ($urandom_range(0, 7))
        0:       lat = HANG;
        1:       lat = TIMEOUT - 1;
        default: lat = int'($urandom_range(0, TIMEOUT - 1));
      endcase
      send_block({$urandom, $urandom}, lat, {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0),
                 {$urandom, $urandom});
      wait_idle();
    end
    bp_mode = 0;
    tick();

    check("final_queue_empty", 64'(out_q.size()), 64'd0);
    check("final_enable_count", 64'(n_en), 64'(n_issued));
    check("final_ack_count", 64'(n_ack), 64'(n_done));
    check("final_blk_count", 64'(blk_count), 64'(cnt_m));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule

// File: doc/des_block_sequencer.md
Name: des_block_sequencer

Overview:
- Feeds a stream of 64-bit blocks through one multi-cycle DES decrypt core (enable/done/ack handshake) and returns the results as a valid/ready stream.
- Owns the key register, issues one core operation per block, and captures and holds each result until the downstream consumer takes it.
- Adds a watchdog on the core's latency and a processed-block counter.
- Sits between the image buffer/DMA side and the DES core.

Parameters:
- TIMEOUT, 64, max cycles in WAIT_DONE before abort (core nominal latency ~70 cycles; the top level overrides this to 128).
- CNT_W, 16, width of the block counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- key_in  in  64  DES key
- key_load  in  1  key write strobe; accepted only in IDLE
- in_data  in  64  ciphertext block
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts in_data this cycle
- out_data  out  64  plaintext block
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- eng_message  out  64  block to core; registered, stable from ISSUE until WAIT_DONE exits
- eng_key  out  64  key register to core
- eng_enable  out  1  start pulse to core
- eng_ack  out  1  result-consumed pulse to core
- eng_result  in  64  core output; valid while eng_done=1
- eng_done  in  1  core finished; held until eng_ack
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err
- blk_count  out  CNT_W  blocks delivered on out

Behaviour:
- Reset values: state IDLE; all outputs 0; key register 0; eng_message 0; watchdog 0; blk_count 0; err 0.
- States: IDLE, ISSUE, WAIT_DONE, ACK, OUT.
- IDLE:
  - in_ready=1.
  - key_load=1 writes the key register. Key writes in any other state are ignored.
  - On in_valid & in_ready, register in_data into eng_message, then go to ISSUE.
  - If key_load and in_valid occur in the same cycle, the key is written first, so this block uses the new key.
- ISSUE:
  - eng_enable=1 for exactly one cycle; clear the watchdog; go to WAIT_DONE.
  - eng_enable is never high in any other state, so the core cannot restart when it returns to its initial state after ack.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - If eng_done=1: capture eng_result into the output register, then go to ACK.
  - Else if watchdog reaches TIMEOUT-1: set err and go to IDLE. The block is dropped, no ack is sent, and blk_count does not change.
  - If done and timeout occur in the same cycle, done wins.
- ACK: eng_ack=1 for one cycle, then go to OUT.
- OUT:
  - out_valid=1 with out_data stable.
  - On out_ready: increment blk_count (wraps at 2^CNT_W−1 → 0), then go to IDLE.
  - out_valid never drops without a handshake.
- Throughput:
  - Minimum in-accept to out_valid is 4 cycles plus core latency.
  - in_ready is low from ISSUE through OUT, so there is no overlap.
- err:
  - Set by timeout; cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
  - err does not block operation.
- Reset mid-operation: returns to IDLE immediately and drops any captured output. The core shares the same reset.

Optional Feature:
- Macro DES_SEQ_CBC_EN.
- When defined:
  - Adds a 64-bit IV register plus inputs iv_in[63:0] and iv_load; iv_load is accepted in IDLE only, like key_load.
  - out_data = eng_result XOR chain register.
  - When the block is accepted at the out handshake, the chain register takes that block's ciphertext.
  - iv_load loads the chain register from iv_in.
  - On timeout, the chain register is unchanged.
- When undefined: ECB mode; out_data = eng_result, with no IV ports or logic.

Test Plan:
- Key load + single block: load key 0x133457799BBCDFF1, send block 0x85E813540F0AB405 with a core model of 20-cycle latency returning 0x0123456789ABCDEF.
  - eng_enable pulses exactly once, eng_ack once.
  - out_data = 0x0123456789ABCDEF; blk_count=1.
  - in-to-out_valid latency = 24 cycles.
- Back-pressure: hold out_ready=0 for 10 cycles.
  - out_valid and out_data stay stable; in_ready=0 throughout.
  - On release, one handshake occurs and the state returns to IDLE.
- Timeout: TIMEOUT=8, core never asserts done.
  - err=1 after 8 WAIT_DONE cycles; no out_valid; blk_count unchanged.
  - Next block processes normally.
  - err_clr and a second timeout in the same cycle: err stays 1.
- Key write ignored while busy: pulse key_load with 0xFFFF… during WAIT_DONE.
  - eng_key keeps its old value; key writes in IDLE take effect.
- Reset mid-WAIT_DONE: assert reset.
  - All outputs 0 in the same cycle; after release, a new block completes correctly.
- CBC (DES_SEQ_CBC_EN): IV=0x1111…, two blocks C1 and C2 with core results P1' and P2'.
  - out1 = P1' ^ IV; out2 = P2' ^ C1.
